// File: rtl/bp_me_wormhole_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bp_me_wormhole_packet_arbiter
//  Purpose  : Packet-level round-robin arbiter sharing one wormhole link
//             among num_in_p wormhole sources. A grant locks on a head flit
//             and is held until the packet's final flit is accepted.
//             Zero-latency passthrough with no flit storage.
//  Ports    : clk_i, reset_i          - clock, async active-high reset
//             link_data_i/v_i         - per-input flits and valids
//             link_ready_and_o        - per-input ready (only selected input)
//             link_data_o/v_o         - output flit and valid
//             link_ready_and_i        - downstream ready
//             grant_o                 - one-hot selected input, 0 if none
//             locked_o                - high while mid-packet
//  Revision : 1.0 - initial release
// ============================================================================
module bp_me_wormhole_packet_arbiter #(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 64,
    parameter int len_width_p  = 4,
    parameter int len_offset_p = 0
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p*flit_width_p-1:0] link_data_i,
    input  logic [num_in_p-1:0]              link_v_i,
    output logic [num_in_p-1:0]              link_ready_and_o,
    output logic [flit_width_p-1:0]          link_data_o,
    output logic                             link_v_o,
    input  logic                             link_ready_and_i,
    output logic [num_in_p-1:0]              grant_o,
    output logic                             locked_o
);

    localparam int ptr_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_idx_lp = ptr_width_lp'(num_in_p - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                   state, state_n;
    logic [ptr_width_lp-1:0]  owner, owner_n;
    logic [ptr_width_lp-1:0]  ptr, ptr_n;
    logic [len_width_p-1:0]   count, count_n;
    logic [ptr_width_lp-1:0]  idle_sel, sel;
    logic                     idle_found, active, accept;
    logic [len_width_p-1:0]   head_len;
    logic [2*num_in_p-1:0]    v_twice, v_shift;
    logic [num_in_p-1:0]      v_rot;
    logic [ptr_width_lp:0]    cand;
    logic [flit_width_p-1:0]  flits [num_in_p];

    for (genvar i = 0; i < num_in_p; i++) begin : g_unpack
        assign flits[i] = link_data_i[i*flit_width_p +: flit_width_p];
    end

    function automatic logic [ptr_width_lp-1:0] next_idx(input logic [ptr_width_lp-1:0] i);
        return (i == last_idx_lp) ? '0 : i + 1'b1;
    endfunction

    // Round-robin search: rotate valids so bit k is input (ptr+k) mod num_in_p,
    // then take the lowest set bit.
    always_comb begin
        idle_found = 1'b0;
        idle_sel   = '0;
        cand       = '0;
        v_twice    = {link_v_i, link_v_i};
        v_shift    = v_twice >> ptr;
        v_rot      = v_shift[num_in_p-1:0];
        for (int k = 0; k < num_in_p; k++) begin
            cand = {1'b0, ptr} + (ptr_width_lp+1)'(k);
            if (cand >= (ptr_width_lp+1)'(num_in_p)) begin
                cand = cand - (ptr_width_lp+1)'(num_in_p);
            end
            if (!idle_found && v_rot[k]) begin
                idle_found = 1'b1;
                idle_sel   = cand[ptr_width_lp-1:0];
            end
        end
    end

    assign sel      = (state == LOCKED) ? owner : idle_sel;
    // The owner keeps its grant through bubbles; outputs are forced quiet while reset is held.
    assign active   = !reset_i && ((state == LOCKED) || idle_found);
    assign link_v_o = active & link_v_i[sel];
    assign link_data_o = flits[sel];
    assign accept   = link_v_o & link_ready_and_i;
    assign head_len = link_data_o[len_offset_p +: len_width_p];
    assign locked_o = (state == LOCKED);

    always_comb begin
        grant_o = '0;
        if (active) begin
            grant_o[sel] = 1'b1;
        end
    end

    assign link_ready_and_o = grant_o & {num_in_p{link_ready_and_i}};

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        count_n = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (head_len == '0) begin
                        ptr_n = next_idx(sel);
                    end else begin
                        owner_n = sel;
                        count_n = head_len;
                        state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    count_n = count - len_width_p'(1);
                    if (count == len_width_p'(1)) begin
                        state_n = IDLE;
                        ptr_n   = next_idx(owner);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            count <= count_n;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(grant_o))
                else $error("grant_o is not one-hot or zero");
            assert ((link_ready_and_o & ~grant_o) == '0)
                else $error("ready asserted on an unselected input");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wormhole_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_me_wormhole_packet_arbiter
//  Purpose  : Self-checking bench for bp_me_wormhole_packet_arbiter with three
//             inputs: directed vector table, reset-mid-packet sequence and
//             randomized traffic against a packet-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_me_wormhole_packet_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int LW = 4;
    localparam int LO = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   v_in;
    logic [N-1:0]   ready_out;
    logic [W-1:0]   data_out;
    logic           v_out;
    logic           ready_in;
    logic [N-1:0]   grant;
    logic           locked;
    logic [W-1:0]   d [N];

    always #5 clk = ~clk;

    assign data_in = {d[2], d[1], d[0]};

    bp_me_wormhole_packet_arbiter #(
        .num_in_p     (N),
        .flit_width_p (W),
        .len_width_p  (LW),
        .len_offset_p (LO)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .link_data_i      (data_in),
        .link_v_i         (v_in),
        .link_ready_and_o (ready_out),
        .link_data_o      (data_out),
        .link_v_o         (v_out),
        .link_ready_and_i (ready_in),
        .grant_o          (grant),
        .locked_o         (locked)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mid-packet flag, owning input, flits still owed, priority pointer.
    int m_locked, m_owner, m_rem, m_ptr;

    // Flit layout: [15:12] source, [11:8] sequence, [7:4] len, [3:0] tag.
    function automatic logic [W-1:0] mk(input int src, input int seq, input int len);
        return {4'(src), 4'(seq), 4'(len), 4'hA};
    endfunction

    function automatic int model_sel(input logic [N-1:0] v);
        int s;
        s = -1;
        if (m_locked != 0) begin
            s = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (s < 0 && v[(m_ptr + k) % N]) s = (m_ptr + k) % N;
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_rem = 0; m_ptr = 0;
    endtask

    task automatic model_update();
        int s;
        logic [W-1:0] f;
        int len;
        s = model_sel(v_in);
        if (s >= 0 && v_in[s] && ready_in) begin
            f   = d[s];
            len = int'(f[LO +: LW]);
            if (m_locked == 0) begin
                if (len == 0) begin
                    m_ptr = (s + 1) % N;
                end else begin
                    m_locked = 1; m_owner = s; m_rem = len;
                end
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end
        end
    endtask

    task automatic compare(input string name, input int esrc, input logic ev, input logic el);
        logic [N-1:0] eg, er;
        logic [W-1:0] ed;
        eg = '0; er = '0; ed = '0;
        if (esrc >= 0) begin
            eg[esrc] = 1'b1;
            er[esrc] = ready_in;
            ed = d[esrc];
        end
        checks++;
        if (grant !== eg || v_out !== ev || ready_out !== er || locked !== el ||
            (ev && data_out !== ed)) begin
            failures++;
            $display("FAIL %s: got grant=%b v=%b ready=%b locked=%b data=%h, expected grant=%b v=%b ready=%b locked=%b data=%h",
                     name, grant, v_out, ready_out, locked, data_out, eg, ev, er, el, ed);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic r);
        @(negedge clk);
        v_in = v; d[0] = a; d[1] = b; d[2] = c; ready_in = r;
        #1;
    endtask

    task automatic model_check(input string name);
        int   s;
        logic ev;
        s  = model_sel(v_in);
        ev = 1'b0;
        if (s >= 0) ev = v_in[s];
        compare(name, s, ev, m_locked != 0);
        model_update();
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic [W-1:0] d0, d1, d2;
        logic         rdy;
        int           esrc;
        logic         ev;
        logic         el;
    } vec_t;

    function automatic vec_t V(input logic [N-1:0] v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic r, input int es,
                               input logic ev, input logic el);
        vec_t t;
        t.v = v; t.d0 = a; t.d1 = b; t.d2 = c; t.rdy = r; t.esrc = es; t.ev = ev; t.el = el;
        return t;
    endfunction

    vec_t tbl [20];
    int   s_len [N];
    int   s_idx [N];

    initial begin
        reset = 1'b1; ready_in = 1'b1; v_in = '1;
        d[0] = mk(0, 0, 0); d[1] = mk(1, 0, 0); d[2] = mk(2, 0, 0);
        model_reset();
        #2;
        compare("reset_quiet", -1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Single-flit packets walk the pointer 0 -> 1 -> 2 -> 0.
        tbl[0]  = V(3'b001, mk(0,0,0), '0,        '0,        1'b1,  0, 1'b1, 1'b0);
        tbl[1]  = V(3'b011, mk(0,1,0), mk(1,0,0), '0,        1'b1,  1, 1'b1, 1'b0);
        tbl[2]  = V(3'b101, mk(0,1,0), '0,        mk(2,0,0), 1'b1,  2, 1'b1, 1'b0);
        // Input 0 sends a len=3 packet while input 1 waits, with a stall and an owner bubble.
        tbl[3]  = V(3'b011, mk(0,0,3), mk(1,0,0), '0,        1'b1,  0, 1'b1, 1'b0);
        tbl[4]  = V(3'b011, mk(0,1,0), mk(1,0,0), '0,        1'b1,  0, 1'b1, 1'b1);
        tbl[5]  = V(3'b011, mk(0,2,0), mk(1,0,0), '0,        1'b0,  0, 1'b1, 1'b1);
        tbl[6]  = V(3'b011, mk(0,2,0), mk(1,0,0), '0,        1'b0,  0, 1'b1, 1'b1);
        tbl[7]  = V(3'b011, mk(0,2,0), mk(1,0,0), '0,        1'b0,  0, 1'b1, 1'b1);
        tbl[8]  = V(3'b011, mk(0,2,0), mk(1,0,0), '0,        1'b1,  0, 1'b1, 1'b1);
        tbl[9]  = V(3'b010, mk(0,3,0), mk(1,0,0), '0,        1'b1,  0, 1'b0, 1'b1);
        tbl[10] = V(3'b010, mk(0,3,0), mk(1,0,0), '0,        1'b1,  0, 1'b0, 1'b1);
        tbl[11] = V(3'b011, mk(0,3,0), mk(1,0,0), '0,        1'b1,  0, 1'b1, 1'b1);
        tbl[12] = V(3'b011, mk(0,0,0), mk(1,0,0), '0,        1'b1,  1, 1'b1, 1'b0);
        // All three sending len=1 packets back to back: order 2,0,1 from pointer 2.
        tbl[13] = V(3'b111, mk(0,0,1), mk(1,0,1), mk(2,0,1), 1'b1,  2, 1'b1, 1'b0);
        tbl[14] = V(3'b111, mk(0,1,0), mk(1,1,0), mk(2,1,0), 1'b1,  2, 1'b1, 1'b1);
        tbl[15] = V(3'b111, mk(0,0,1), mk(1,0,1), mk(2,0,1), 1'b1,  0, 1'b1, 1'b0);
        tbl[16] = V(3'b111, mk(0,1,0), mk(1,1,0), mk(2,1,0), 1'b1,  0, 1'b1, 1'b1);
        tbl[17] = V(3'b111, mk(0,0,1), mk(1,0,1), mk(2,0,1), 1'b1,  1, 1'b1, 1'b0);
        tbl[18] = V(3'b111, mk(0,1,0), mk(1,1,0), mk(2,1,0), 1'b1,  1, 1'b1, 1'b1);
        tbl[19] = V(3'b000, '0,        '0,        '0,        1'b1, -1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
            compare($sformatf("vec%0d", i), tbl[i].esrc, tbl[i].ev, tbl[i].el);
            model_update();
        end

        // Reset in the middle of a packet (counter at 2), then fresh arbitration.
        drive(3'b001, mk(0,0,3), '0, '0, 1'b1);
        model_check("rst_head");
        drive(3'b001, mk(0,1,0), '0, '0, 1'b1);
        model_check("rst_body");
        @(negedge clk);
        v_in = 3'b111; d[0] = mk(0,0,0); d[1] = mk(1,0,0); d[2] = mk(2,0,0); ready_in = 1'b1;
        reset = 1'b1;
        #1;
        compare("rst_async", -1, 1'b0, 1'b0);
        model_reset();
        #2;
        reset = 1'b0;
        #1;
        model_check("rst_fresh0");
        drive(3'b111, mk(0,0,0), mk(1,0,0), mk(2,0,0), 1'b1);
        model_check("rst_fresh1");

        // Randomized traffic from well-formed packet sources.
        for (int i = 0; i < N; i++) begin
            s_len[i] = int'($urandom_range(0, 5));
            s_idx[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            int s;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                v_in[i] = ($urandom_range(0, 9) < 7);
                if (s_idx[i] == 0) d[i] = mk(i, 0, s_len[i]);
                else               d[i] = mk(i, s_idx[i], int'($urandom_range(0, 15)));
            end
            ready_in = ($urandom_range(0, 3) != 0);
            #1;
            s = model_sel(v_in);
            if (s >= 0 && v_in[s] && ready_in) begin
                s_idx[s] = s_idx[s] + 1;
                if (s_idx[s] > s_len[s]) begin
                    s_idx[s] = 0;
                    s_len[s] = int'($urandom_range(0, 5));
                end
            end
            model_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_me_wormhole_packet_arbiter.md
Name: bp_me_wormhole_packet_arbiter

Overview:
- Packet-level round-robin arbiter that shares one wormhole link between num_in_p wormhole stream sources, e.g. several stream-to-wormhole converters feeding one router port.
- Grant locks on a head flit and is held until the final flit of that packet is accepted, so flits from different packets never interleave.
- Zero-latency passthrough: no flit storage.
- Packet length is taken from the len field of each head flit.

Parameters:
- num_in_p, 2, number of requesting input links (>=1).
- flit_width_p, 64, wormhole flit width in bits.
- len_width_p, 4, width of the wormhole len field.
- len_offset_p, 0, bit offset of the len field within the head flit (normally cord_width_p).

Ports:
- clk_i  input  1  clock
- reset_i  input  1  asynchronous active-high reset
- link_data_i  input  num_in_p*flit_width_p  input flits; input i occupies bits [i*flit_width_p +: flit_width_p]
- link_v_i  input  num_in_p  per-input flit valid
- link_ready_and_o  output  num_in_p  per-input ready&valid ready
- link_data_o  output  flit_width_p  output flit
- link_v_o  output  1  output flit valid
- link_ready_and_i  input  1  downstream ready
- grant_o  output  num_in_p  one-hot selected input; all zero when nothing is selected
- locked_o  output  1  high while the arbiter is mid-packet

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- Reset values:
  - state=IDLE, owner=0, flit counter=0.
  - Priority pointer=0, so input 0 has highest priority.
  - locked_o=0.
  - link_v_o, link_ready_and_o and grant_o are combinational; during reset they are 0.
- Handshake:
  - Output flit accepted when link_v_o & link_ready_and_i.
  - link_data_o = selected input's data. link_v_o = link_v_i[sel].
  - link_ready_and_o[sel] = link_ready_and_i. All other ready bits are 0.
  - No added latency or buffering. ready_and_o depends combinationally on link_v_i (arbitration), which is permitted.
- Length convention: len = number of flits following the head flit. A len of 0 means a single-flit packet.
- IDLE:
  - sel = first input with link_v_i set, searching from the priority pointer upward with wrap-around. grant_o = one-hot(sel), or 0 if no input is valid.
  - On acceptance with len==0: stay IDLE; pointer <= sel+1 mod num_in_p.
  - On acceptance with len!=0: owner <= sel, counter <= len, go to LOCKED.
  - With no acceptance, the pointer does not move. Selection may change between cycles while downstream stalls, since no flit has been committed.
- LOCKED:
  - sel = owner. grant_o = one-hot(owner), even while link_v_i[owner] is 0. locked_o=1.
  - Other inputs always see ready 0.
  - Each accepted flit decrements the counter.
  - When a flit is accepted with counter==1: go to IDLE and set pointer <= owner+1 mod num_in_p. The next packet can be granted in the following cycle.
  - Owner bubble (link_v_i[owner]=0): link_v_o=0, state held.
- Counter width: len_width_p. Maximum packet = 2^len_width_p flits (head + max len); no overflow is possible.
- num_in_p==1: pointer and owner are constant 0. The lock and counter still track packets so that locked_o is valid.
- Reset mid-packet: returns to IDLE immediately. The partial packet is abandoned, and upstream sources are reset together.
- Assertions (simulation only): grant_o one-hot or zero; no ready bit asserted on an input other than sel.

Test Plan:
- Single input 0, head len=0, downstream ready -> flit passes through in the same cycle; locked_o stays 0; pointer moves to 1.
- Inputs 0 and 1 both valid; input 0 head len=3 -> 4 flits from input 0 contiguously; input 1 ready=0 throughout; input 1 head granted on cycle 5.
- Downstream ready=0 for 3 cycles mid-packet (counter=2) -> counter holds at 2, owner unchanged, data_o stable; completes after ready returns.
- Owner drops valid for 2 cycles mid-packet while input 1 is valid -> link_v_o=0, input 1 not granted, locked_o=1; lock persists until the owner's last flit.
- num_in_p=3, all inputs continuously sending len=1 packets -> grant order 0,1,2,0,1,2; each packet is 2 flits, back-to-back with no idle cycle.
- Assert reset_i when counter=2 -> locked_o=0 and grant returns to input 0 priority immediately (asynchronous); the next head is arbitrated fresh.
